// File: rtl/l2_line_fill_engine.sv
// rtl/l2_line_fill_engine.sv - L2 line-fill engine: eviction write, latency-modelled read, neighbour cancel.
// Optional counters enabled by L2_FILL_STATS_EN.
module l2_line_fill_engine #(
  parameter int MEM_LINES  = 1024,
  parameter int RD_LATENCY = 8,
  parameter int WR_LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_req_valid,
  input  logic [31:0]  i_req_addr,
  output logic         o_req_ready,
  input  logic         i_evict_valid,
  input  logic [31:0]  i_evict_addr,
  input  logic [127:0] i_evict_line,
  input  logic         i_neighbour_hit,
  output logic [127:0] o_resp_line,
  output logic         o_resp_valid,
`ifdef L2_FILL_STATS_EN
  output logic [15:0]  o_stat_fills,
  output logic [15:0]  o_stat_evicts,
  output logic [15:0]  o_stat_cancels,
`endif
  output logic         o_busy
);

  localparam int IDX_W   = $clog2(MEM_LINES);
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_EVICT_WAIT, S_READ_WAIT, S_RESP
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_req_idx, r_evict_idx;
  logic [127:0]       r_evict_line;
  logic               r_evict_valid;
  logic               r_nbr_hit;
  logic [CNT_W-1:0]   r_cnt;
  logic [127:0]       r_mem [MEM_LINES];

  logic w_cnt_zero, w_load_wr, w_load_rd, w_evict_commit, w_read_load, w_cancel;

  assign w_cnt_zero  = (r_cnt == '0);
  assign o_req_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt    = r_state;
    w_load_wr      = 1'b0;
    w_load_rd      = 1'b0;
    w_evict_commit = 1'b0;
    w_read_load    = 1'b0;
    w_cancel       = 1'b0;
    case (r_state)
      S_IDLE: if (i_req_valid) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (i_evict_valid) begin
          w_state_nxt = S_EVICT_WAIT;
          w_load_wr   = 1'b1;
        end else if (i_neighbour_hit) begin
          w_state_nxt = S_IDLE;
          w_cancel    = 1'b1;
        end else begin
          w_state_nxt = S_READ_WAIT;
          w_load_rd   = 1'b1;
        end
      end
      S_EVICT_WAIT: if (w_cnt_zero) begin
        // The eviction always lands, even when the sister core already answered.
        w_evict_commit = 1'b1;
        w_cancel       = r_nbr_hit;
        w_load_rd      = !r_nbr_hit;
        w_state_nxt    = r_nbr_hit ? S_IDLE : S_READ_WAIT;
      end
      S_READ_WAIT: if (w_cnt_zero) begin
        w_read_load = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_req_idx     <= '0;
      r_evict_idx   <= '0;
      r_evict_line  <= '0;
      r_evict_valid <= 1'b0;
      r_nbr_hit     <= 1'b0;
      o_resp_valid  <= 1'b0;
      o_resp_line   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      o_resp_valid <= w_read_load;
      if (r_state == S_IDLE && i_req_valid) r_req_idx <= i_req_addr[IDX_W+3:4];
      if (r_state == S_CHECK) begin
        r_evict_valid <= i_evict_valid;
        r_evict_idx   <= i_evict_addr[IDX_W+3:4];
        r_evict_line  <= i_evict_line;
        r_nbr_hit     <= i_neighbour_hit;
      end
      if (w_load_wr)      r_cnt <= CNT_W'(WR_LATENCY - 1);
      else if (w_load_rd) r_cnt <= CNT_W'(RD_LATENCY - 1);
      else if (r_state == S_EVICT_WAIT || r_state == S_READ_WAIT) r_cnt <= r_cnt - 1'b1;
      // Commit always precedes the read edge, so a same-line read sees the eviction.
      if (w_read_load) o_resp_line <= r_mem[r_req_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_evict_commit) r_mem[r_evict_idx] <= r_evict_line;
  end

`ifdef L2_FILL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      o_stat_fills   <= '0;
      o_stat_evicts  <= '0;
      o_stat_cancels <= '0;
    end else begin
      if (w_read_load && o_stat_fills != 16'hFFFF)    o_stat_fills   <= o_stat_fills + 1'b1;
      if (w_evict_commit && o_stat_evicts != 16'hFFFF) o_stat_evicts  <= o_stat_evicts + 1'b1;
      if (w_cancel && o_stat_cancels != 16'hFFFF)      o_stat_cancels <= o_stat_cancels + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_line_fill_engine.sv
// tb/tb_l2_line_fill_engine.sv - scoreboard bench for l2_line_fill_engine against a line-array model.
module tb_l2_line_fill_engine;
  localparam int MEM_LINES = 1024;
  localparam int RD_LAT = 8;
  localparam int WR_LAT = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_req_valid = 1'b0;
  logic [31:0]  i_req_addr = '0;
  logic         o_req_ready;
  logic         i_evict_valid = 1'b0;
  logic [31:0]  i_evict_addr = '0;
  logic [127:0] i_evict_line = '0;
  logic         i_neighbour_hit = 1'b0;
  logic [127:0] o_resp_line;
  logic         o_resp_valid;
  logic         o_busy;

  l2_line_fill_engine #(.MEM_LINES(MEM_LINES), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .o_req_ready(o_req_ready),
    .i_evict_valid(i_evict_valid), .i_evict_addr(i_evict_addr), .i_evict_line(i_evict_line),
    .i_neighbour_hit(i_neighbour_hit),
    .o_resp_line(o_resp_line), .o_resp_valid(o_resp_valid), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] line;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] mdl [MEM_LINES];
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;
  int           busy_from = 0;
  int           busy_to = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lidx(input logic [31:0] a);
    return int'(a / 16) % MEM_LINES;
  endfunction

  // Monitor: response data/timing against the scoreboard, and the busy window.
  always @(negedge clk) begin
    if (!reset) begin
      logic exp_busy;
      exp_t e;
      exp_busy = (cyc >= busy_from) && (cyc < busy_to);
      check("busy", 128'(o_busy), 128'(exp_busy));
      check("req_ready", 128'(o_req_ready), 128'(!exp_busy));
      if (o_resp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 128'(1), 128'(0));
        end else begin
          e = sb_q.pop_front();
          check("resp_line", o_resp_line, e.line);
          check("resp_cycle", 128'(cyc), 128'(e.cyc));
        end
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!o_req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("ready_timeout", 128'(o_req_ready), 128'(1));
  endtask

  task automatic issue(input logic [31:0] raddr, input bit ev, input logic [31:0] eaddr,
                       input logic [127:0] eline, input bit nbr, input bit pulse);
    int   e0;
    exp_t e;
    wait_ready();
    i_req_valid = 1'b1;
    i_req_addr  = raddr;
    @(posedge clk);
    #1;
    e0 = cyc;
    i_req_valid     = 1'b0;
    i_req_addr      = $urandom;
    i_evict_valid   = ev;
    i_evict_addr    = eaddr;
    i_evict_line    = eline;
    i_neighbour_hit = nbr;
    if (ev) mdl[lidx(eaddr)] = eline;
    busy_from = e0;
    if (nbr) busy_to = e0 + 1 + (ev ? WR_LAT : 0);
    else begin
      busy_to = e0 + 2 + RD_LAT + (ev ? WR_LAT : 0);
      e.line = mdl[lidx(raddr)];
      e.cyc  = e0 + 1 + RD_LAT + (ev ? WR_LAT : 0);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    i_evict_valid   = $urandom_range(0, 1);
    i_evict_addr    = $urandom;
    i_evict_line    = {$urandom, $urandom, $urandom, $urandom};
    i_neighbour_hit = $urandom_range(0, 1);
    if (pulse && !nbr) begin
      repeat (2) @(negedge clk);
      i_req_valid = 1'b1;
      i_req_addr  = $urandom;
      @(negedge clk);
      i_req_valid = 1'b0;
    end
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_resp_valid", 128'(o_resp_valid), 128'(0));
    check("rst_resp_line", o_resp_line, 128'(0));
    check("rst_busy", 128'(o_busy), 128'(0));
    check("rst_req_ready", 128'(o_req_ready), 128'(1));
  endtask

  // Accept an eviction request, then reset during EVICT_WAIT: nothing may be written.
  task automatic issue_reset(input logic [31:0] raddr, input logic [31:0] eaddr, input logic [127:0] eline);
    wait_ready();
    i_req_valid = 1'b1;
    i_req_addr  = raddr;
    @(posedge clk);
    #1;
    busy_from       = cyc;
    busy_to         = cyc + 1000;
    i_req_valid     = 1'b0;
    i_evict_valid   = 1'b1;
    i_evict_addr    = eaddr;
    i_evict_line    = eline;
    i_neighbour_hit = 1'b0;
    @(posedge clk);
    #1;
    i_evict_valid = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    busy_to = cyc + 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state();
  endtask

  initial begin
    logic [127:0] pa5, pdead, p1234;
    int t;
    pa5   = {16{8'hA5}};
    pdead = {8{16'hDEAD}};
    p1234 = {8{16'h1234}};
    for (int i = 0; i < MEM_LINES; i++) mdl[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state();

    issue(32'h0, 1'b1, 32'h0000_0050, pa5, 1'b1, 1'b0);
    issue(32'h0000_0050, 1'b0, 32'h0, 128'h0, 1'b0, 1'b0);
    issue(32'h0000_0030, 1'b1, 32'h0000_0100, pdead, 1'b0, 1'b0);
    issue(32'h0000_0100, 1'b0, 32'h0, 128'h0, 1'b0, 1'b0);
    issue(32'h0000_0200, 1'b1, 32'h0000_0200, p1234, 1'b0, 1'b0);
    issue(32'h0000_0070, 1'b0, 32'h0, 128'h0, 1'b1, 1'b0);
    issue(32'h0001_0050, 1'b0, 32'h0, 128'h0, 1'b0, 1'b1);
    issue_reset(32'h0000_0040, 32'h0000_0500, pdead);
    issue(32'h0000_0500, 1'b0, 32'h0, 128'h0, 1'b0, 1'b0);
    issue(32'h0000_0200, 1'b0, 32'h0, 128'h0, 1'b0, 1'b1);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] ra, ea;
      ra = {$urandom_range(0, 255) << 14} | (32'($urandom_range(0, 31)) << 4) | 32'($urandom_range(0, 15));
      ea = {$urandom_range(0, 255) << 14} | (32'($urandom_range(0, 31)) << 4) | 32'($urandom_range(0, 15));
      issue(ra, $urandom_range(0, 1) == 1, ea, {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end

    t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
